// File: rtl/tt_response_checker_if.sv
// Handshake and result bundle between the stimulus sweep and the response checker.
interface tt_response_checker_if;
   logic        start;
   logic        vec_valid;
   logic [3:0]  vec;
   logic        f;
   logic        busy;
   logic        done;
   logic        fail;
   logic [15:0] captured;
   logic [15:0] covered;
   logic [4:0]  mismatch_cnt;
   logic [3:0]  first_fail;

   // Stimulus side: applies vectors, observes results
   modport master (
      output start, vec_valid, vec, f,
      input  busy, done, fail, captured, covered, mismatch_cnt, first_fail
   );

   // Checker side
   modport slave (
      input  start, vec_valid, vec, f,
      output busy, done, fail, captured, covered, mismatch_cnt, first_fail
   );
endinterface

// File: rtl/tt_response_checker.sv
// Samples the output of a 4-input combinational block after a settle delay,
// builds its truth table and judges it against an expected table.
module tt_response_checker #(
   parameter logic [15:0] EXPECTED = 16'h0000,
   parameter int unsigned SETTLE   = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   tt_response_checker_if.slave bus
);

   localparam int unsigned NVEC = 16;
   localparam int unsigned VW   = 4;
   localparam int unsigned CW   = 4;
   localparam int unsigned MW   = 5;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_SETTLING,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [VW-1:0]   vec_q, vec_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NVEC-1:0] captured_q, captured_d;
   logic [NVEC-1:0] covered_q, covered_d;
   logic [MW-1:0]   mcnt_q, mcnt_d;
   logic [VW-1:0]   ffail_q, ffail_d;
   logic            fail_q, fail_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [NVEC-1:0] onehot_c;

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         cnt_q      <= '0;
         captured_q <= '0;
         covered_q  <= '0;
         mcnt_q     <= '0;
         ffail_q    <= '0;
         fail_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         captured_q <= captured_d;
         covered_q  <= covered_d;
         mcnt_q     <= mcnt_d;
         ffail_q    <= ffail_d;
         fail_q     <= fail_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state, sampling and judging; start aborts/clears from any state
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      captured_d = captured_q;
      covered_d  = covered_q;
      mcnt_d     = mcnt_q;
      ffail_d    = ffail_q;
      fail_d     = fail_q;
      onehot_c   = NVEC'(1) << vec_q;

      if (bus.start) begin
         captured_d = '0;
         covered_d  = '0;
         mcnt_d     = '0;
         ffail_d    = '0;
         fail_d     = 1'b0;
         cnt_d      = '0;
         state_d    = S_ARMED;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (bus.vec_valid) begin
                  vec_d   = bus.vec;
                  cnt_d   = SETTLE_LOAD;
                  state_d = S_SETTLING;
               end
            end
            S_SETTLING: begin
               if (cnt_q == '0) begin
                  captured_d[vec_q] = bus.f;
                  covered_d[vec_q]  = 1'b1;
                  // Only the first sample of a vector is judged
                  if (!covered_q[vec_q] && (bus.f != EXPECTED[vec_q])) begin
                     mcnt_d = mcnt_q + MW'(1);
                     fail_d = 1'b1;
                     if (!fail_q) begin
                        ffail_d = vec_q;
                     end
                  end
                  state_d = ((covered_q | onehot_c) == '1) ? S_DONE : S_ARMED;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
               // A new vector replaces any pending one (after a same-edge sample)
               if (bus.vec_valid) begin
                  vec_d   = bus.vec;
                  cnt_d   = SETTLE_LOAD;
                  state_d = S_SETTLING;
               end
            end
            default: begin
            end
         endcase
      end

      busy_d = (state_d == S_ARMED) || (state_d == S_SETTLING);
      done_d = (state_d == S_DONE);
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.fail         = fail_q;
   assign bus.captured     = captured_q;
   assign bus.covered      = covered_q;
   assign bus.mismatch_cnt = mcnt_q;
   assign bus.first_fail   = ffail_q;

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Response-side counterpart to the exhaustive 4-input stimulus sweep used on the combinational `test` block (inputs a/b/c/d, output f).
- Receives each applied input vector plus the DUT output f, waits a programmable settle time, then samples f.
- Builds the captured 16-entry truth table, tracks which vectors have been covered, compares against an expected truth table, and reports pass/fail once all 16 vectors are seen.
- Sits between the stimulus generator and the status/LED logic on the lab board.

Parameters:
- EXPECTED, 16'h0000: expected truth table; bit i = required f for vector i, where i = {a,b,c,d} and a is the MSB.
- SETTLE, 2: clock cycles from accepting a vector to sampling f. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears results and arms collection
- vec_valid  input  1  one-cycle pulse; vec has just been applied to the DUT
- vec  input  4  applied vector {a,b,c,d}
- f  input  1  DUT output under test
- busy  output  1  high in ARMED and SETTLING
- done  output  1  high once all 16 vectors are covered; held until start or reset
- fail  output  1  at least one first-sample mismatch recorded
- captured  output  16  bit i = last sampled f for vector i
- covered  output  16  bit i = vector i sampled at least once
- mismatch_cnt  output  5  number of vectors whose first sample differed from EXPECTED (0..16)
- first_fail  output  4  vector index of the first mismatch; valid only when fail=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, internal vec_q=0, settle counter=0.
- FSM states: IDLE, ARMED, SETTLING, DONE.
- IDLE:
  - busy=0.
  - start -> clear captured, covered, mismatch_cnt, first_fail, fail, done; go to ARMED.
  - vec_valid is ignored.
- ARMED:
  - busy=1.
  - vec_valid -> latch vec_q=vec, load counter=SETTLE-1, go to SETTLING.
- SETTLING:
  - busy=1.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, f is sampled at the clock edge. Net effect: f is sampled on the SETTLE-th rising edge after the edge that registered vec_valid.
  - On that sample edge:
    - captured[vec_q] = f.
    - covered[vec_q] = 1.
    - If covered[vec_q] was previously 0 and f != EXPECTED[vec_q]: mismatch_cnt += 1; fail = 1; if fail was 0, first_fail = vec_q.
    - Next state: DONE if (covered | onehot(vec_q)) == 16'hFFFF, otherwise ARMED.
- Repeated vector: captured is overwritten with the new f; coverage, mismatch_cnt and fail are unchanged (only the first sample is judged).
- vec_valid while SETTLING: the pending vector is discarded; re-latch vec_q, reload the counter, stay in SETTLING. The latest vector wins.
- vec_valid on the same edge as the sample edge: the sample completes for the old vq_q first, then the new vector is latched and the state goes to SETTLING. This applies even if the sample would complete coverage; in that case DONE is entered only after the new vector's sample.
- DONE:
  - done=1, busy=0.
  - All results are held stable.
  - vec_valid is ignored.
  - start re-clears results and goes to ARMED.
- start in ARMED or SETTLING: abort. Clear results, drop any pending vector, go to ARMED.
- start has priority over vec_valid in the same cycle.
- Reset asserted mid-sweep: immediate return to the reset values. No partial results are retained.
- mismatch_cnt saturates naturally at 16 (each vector is counted at most once).
- All outputs are registered; none depend combinationally on the inputs.

Test Plan:
- Full correct sweep:
  - Setup: EXPECTED=16'h8001, SETTLE=2. Pulse start, then vectors 0..15, one every 4 cycles, with f=1 only for vectors 0 and 15.
  - Required: done=1 after the 16th sample; fail=0; mismatch_cnt=0; captured=16'h8001; covered=16'hFFFF.
- Mismatches:
  - Stimulus: same sweep, but f=1 also for vectors 5 and 9.
  - Required: fail=1; mismatch_cnt=2; first_fail=4'd5; captured=16'h8221.
- Settle timing:
  - Setup: SETTLE=3. Vector 7 is accepted; f=0 until the 2nd edge after acceptance, then f=1.
  - Required: captured[7]=1, sampled exactly on the 3rd edge.
  - Check: a sweep where f changes after the 3rd edge still records 0.
- Repeat and retrigger:
  - Stimulus: vector 3 twice, with f=1 on the first sample and f=0 on the second.
  - Required: mismatch_cnt increments once only (EXPECTED[3]=0); captured[3]=0.
  - Stimulus: vec_valid for vector 4 during SETTLING of vector 2.
  - Required: only covered[4] is set; covered[2]=0.
- Abort and reset:
  - Stimulus: start pulsed after 8 vectors.
  - Required: covered=0; mismatch_cnt=0; busy=1.
  - Stimulus: rst_n low mid-SETTLING.
  - Required: all outputs are 0 asynchronously; a subsequent vec_valid without start is ignored.
- DONE hold:
  - Stimulus: after done, drive vec_valid with different f values.
  - Required: captured, covered and mismatch_cnt unchanged; done stays 1 until start.
